// File: rtl/ballot_pkg.sv
// ballot_pkg
// Shared definitions for the three-voter ballot link. Both the transmit side
// and the remote evaluator use this package, so they have one definition of
// the frame states, the line levels and the majority function.
//   state_t     : frame state encoding (IDLE, START, D0, D1, D2, PAR, STP)
//   maj3        : majority of three votes
//   frame_level : serial line level driven while in a given state
package ballot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      D0,
      D1,
      D2,
      PAR,
      STP
   } state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam int   FRAME_BITS  = 6;

   function automatic logic maj3(input logic t, input logic h, input logic p);
      return (t & h) | (t & p) | (h & p);
   endfunction

   // ballot is packed {T,H,P}; the data bits go out in T, H, P order.
   function automatic logic frame_level(input state_t s, input logic [2:0] ballot);
      logic lvl;
      lvl = IDLE_LEVEL;
      case (s)
         IDLE:    lvl = IDLE_LEVEL;
         START:   lvl = START_LEVEL;
         D0:      lvl = ballot[2];
         D1:      lvl = ballot[1];
         D2:      lvl = ballot[0];
         PAR:     lvl = ^ballot;
         STP:     lvl = STOP_LEVEL;
         default: lvl = IDLE_LEVEL;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/ballot_bit_timer.sv
// ballot_bit_timer
// Bit-period down-counter. A start pulse loads BIT_CYCLES-1; while run is
// high the count decrements and tick marks the last cycle of a bit period,
// at which point the counter reloads for the next bit.
//   clk_sys : clock
//   rst_b   : asynchronous active-low reset
//   start   : load the bit period (takes priority over run)
//   run     : count enable
//   tick    : last cycle of the current bit period
module ballot_bit_timer #(
   parameter int BIT_CYCLES = 4
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic start,
   input  logic run,
   output logic tick
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] TC_LOAD = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] count;

   assign tick = run && (count == '0);

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         count <= '0;
      end else if (start) begin
         count <= TC_LOAD;
      end else if (run) begin
         if (count == '0) count <= TC_LOAD;
         else             count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/ballot_tx.sv
// ballot_tx
// Transmit side of the three-voter ballot link. Captures {T,H,P} on an
// accepted load, registers the local majority, and shifts out a framed
// serial stream: START, T, H, P, even PARITY, STOP, each bit BIT_CYCLES long.
//   Clock  : system clock
//   Resetn : asynchronous active-low reset
//   T,H,P  : vote bits, sampled only on an accepted load
//   Load   : load request, level-sampled
//   Ready  : idle, a load this cycle is accepted
//   SerOut : serial line, idles high
//   Done   : one-cycle pulse when a frame completes
//   Maj    : majority of the last accepted ballot
//
// state | meaning
// IDLE  | line high, waiting for load
// START | start bit (low)
// D0    | vote T
// D1    | vote H
// D2    | vote P
// PAR   | even parity of T,H,P
// STP   | stop bit (high)
module ballot_tx
   import ballot_pkg::*;
#(
   parameter int BIT_CYCLES = 4
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic T,
   input  logic H,
   input  logic P,
   input  logic Load,
   output logic Ready,
   output logic SerOut,
   output logic Done,
   output logic Maj
);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] ballot;
   logic [2:0] ballot_nxt;
   logic       accept;
   logic       tick;
   logic       ser_nxt;
   logic       done_nxt;

   ballot_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_timer (
      .clk_sys (Clock),
      .rst_b   (Resetn),
      .start   (accept),
      .run     (state != IDLE),
      .tick    (tick)
   );

   assign Ready = (state == IDLE);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state  <= IDLE;
         ballot <= 3'b000;
         SerOut <= IDLE_LEVEL;
         Done   <= 1'b0;
         Maj    <= 1'b0;
      end else begin
         state  <= state_nxt;
         ballot <= ballot_nxt;
         SerOut <= ser_nxt;
         Done   <= done_nxt;
         if (accept) Maj <= maj3(T, H, P);
      end
   end

   always_comb begin
      state_nxt  = state;
      ballot_nxt = ballot;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (Load) begin
               accept     = 1'b1;
               ballot_nxt = {T, H, P};
               state_nxt  = START;
            end
         end
         START:   if (tick) state_nxt = D0;
         D0:      if (tick) state_nxt = D1;
         D1:      if (tick) state_nxt = D2;
         D2:      if (tick) state_nxt = PAR;
         PAR:     if (tick) state_nxt = STP;
         STP:     if (tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // SerOut is registered, so it follows the level of the state being entered.
      ser_nxt  = frame_level(state_nxt, ballot_nxt);
      done_nxt = (state == STP) && tick;
   end

endmodule

// File: tb/tb_ballot_tx.sv
module tb_ballot_tx;
   import ballot_pkg::*;

   typedef struct {
      logic [5:0] frame;
      logic       maj;
   } exp_t;

   typedef struct {
      bit         active;
      bit         expect_done;
      int         cyc;
      logic [5:0] bits;
      logic       maj;
   } mon_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst4_n, t4, h4, p4, ld4, rdy4, ser4, done4, maj4;
   logic rst1_n, t1, h1, p1, ld1, rdy1, ser1, done1, maj1;

   ballot_tx #(.BIT_CYCLES(4)) dut4 (
      .Clock(clk), .Resetn(rst4_n), .T(t4), .H(h4), .P(p4), .Load(ld4),
      .Ready(rdy4), .SerOut(ser4), .Done(done4), .Maj(maj4)
   );

   ballot_tx #(.BIT_CYCLES(1)) dut1 (
      .Clock(clk), .Resetn(rst1_n), .T(t1), .H(h1), .P(p1), .Load(ld1),
      .Ready(rdy1), .SerOut(ser1), .Done(done1), .Maj(maj1)
   );

   int total = 0;
   int bad   = 0;

   // Hand-computed frames, bit 0 first on the line: {STOP,PAR,P,H,T,START}.
   // Index is the ballot {T,H,P}.
   logic [5:0] frame_tab [8] = '{6'b100000, 6'b111000, 6'b110100, 6'b101100,
                                 6'b110010, 6'b101010, 6'b100110, 6'b111110};
   logic       maj_tab   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   exp_t q4[$];
   exp_t q1[$];
   mon_t m4, m1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon_tick(input int bc, input logic rstn, input logic ready, input logic ser,
                           input logic done, input logic maj, inout mon_t m, output bit got);
      int idx;
      got = 1'b0;
      if (!rstn) begin
         m.active = 1'b0;
         m.expect_done = 1'b0;
         return;
      end
      if (m.expect_done) begin
         check("done_pulse", done, 1'b1);
         check("ready_at_done", ready, 1'b1);
         m.expect_done = 1'b0;
         got = 1'b1;
      end else if (!m.active) begin
         check("done_idle", done, 1'b0);
      end
      if (!m.active && !ready) begin
         m.active = 1'b1;
         m.cyc    = 0;
         m.maj    = maj;
      end
      if (m.active) begin
         idx = m.cyc / bc;
         if (m.cyc % bc == 0) m.bits[idx] = ser;
         else check("bit_hold", ser, m.bits[idx]);
         check("done_in_frame", done, 1'b0);
         check("ready_in_frame", ready, 1'b0);
         m.cyc++;
         if (m.cyc == FRAME_BITS * bc) begin
            m.active = 1'b0;
            m.expect_done = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      bit   got;
      exp_t e;
      mon_tick(4, rst4_n, rdy4, ser4, done4, maj4, m4, got);
      if (got) begin
         if (q4.size() == 0) check("sb4_empty", 1, 0);
         else begin
            e = q4.pop_front();
            check("frame4", m4.bits, e.frame);
            check("maj4", m4.maj, e.maj);
         end
      end
      mon_tick(1, rst1_n, rdy1, ser1, done1, maj1, m1, got);
      if (got) begin
         if (q1.size() == 0) check("sb1_empty", 1, 0);
         else begin
            e = q1.pop_front();
            check("frame1", m1.bits, e.frame);
            check("maj1", m1.maj, e.maj);
         end
      end
   end

   task automatic push4(input logic [2:0] b);
      exp_t e;
      e.frame = frame_tab[b];
      e.maj   = maj_tab[b];
      q4.push_back(e);
   endtask

   task automatic push1(input logic [2:0] b);
      exp_t e;
      e.frame = frame_tab[b];
      e.maj   = maj_tab[b];
      q1.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send4(input logic [2:0] b, input bit push);
      t4 = b[2]; h4 = b[1]; p4 = b[0];
      ld4 = 1'b1;
      if (push) push4(b);
      @(negedge clk);
      ld4 = 1'b0;
   endtask

   task automatic wait_done(input int sel, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (sel == 4 ? done4 : done1) seen = 1'b1;
      end
      if (!seen) check({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      rst4_n = 1'b0; rst1_n = 1'b0;
      {t4, h4, p4, ld4} = 4'b0;
      {t1, h1, p1, ld1} = 4'b0;
      m4 = '{default: 0};
      m1 = '{default: 0};
      repeat (3) @(negedge clk);
      check("rst_ser", ser4, 1'b1);
      check("rst_ready", rdy4, 1'b1);
      check("rst_done", done4, 1'b0);
      check("rst_maj", maj4, 1'b0);
      rst4_n = 1'b1; rst1_n = 1'b1;

      // idle
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_ser", ser4, 1'b1);
         check("idle_ready", rdy4, 1'b1);
         check("idle_done", done4, 1'b0);
         check("idle_maj", maj4, 1'b0);
      end

      // single frame T=1,H=0,P=1
      send4(3'b101, 1'b1);
      check("maj_after_load", maj4, 1'b1);
      wait_done(4, "t2");

      // T=0,H=0,P=1 with mid-frame disturbance on votes and Load
      send4(3'b001, 1'b1);
      repeat (5) @(negedge clk);
      t4 = 1'b1; h4 = 1'b1; p4 = 1'b0; ld4 = 1'b1;
      @(negedge clk);
      ld4 = 1'b0;
      repeat (3) @(negedge clk);
      check("maj_unchanged", maj4, 1'b0);
      wait_done(4, "t3");

      // continuous load: 110 then 011
      t4 = 1'b1; h4 = 1'b1; p4 = 1'b0; ld4 = 1'b1;
      push4(3'b110);
      @(negedge clk);
      t4 = 1'b0; h4 = 1'b1; p4 = 1'b1;
      push4(3'b011);
      wait_done(4, "t4a");
      @(negedge clk);
      check("b2b_ready", rdy4, 1'b0);
      check("b2b_start", ser4, 1'b0);
      ld4 = 1'b0;
      wait_done(4, "t4b");

      // reset during D1 (cycles 8..11 of the frame)
      @(negedge clk);
      send4(3'b101, 1'b0);
      repeat (9) @(negedge clk);
      #1 rst4_n = 1'b0;
      #1;
      check("abort_ser", ser4, 1'b1);
      check("abort_ready", rdy4, 1'b1);
      check("abort_done", done4, 1'b0);
      check("abort_maj", maj4, 1'b0);
      @(negedge clk);
      #1 rst4_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("abort_no_done", done4, 1'b0);
      end
      send4(3'b101, 1'b1);
      wait_done(4, "t5");

      // BIT_CYCLES=1, all 8 ballots back-to-back
      @(negedge clk);
      {t1, h1, p1} = 3'd0;
      ld1 = 1'b1;
      push1(3'd0);
      @(negedge clk);
      for (int i = 1; i < 8; i++) begin
         logic [2:0] b;
         b = 3'(i);
         wait_done(1, "t6");
         {t1, h1, p1} = b;
         push1(b);
      end
      @(negedge clk);
      ld1 = 1'b0;
      wait_done(1, "t6_last");

      repeat (3) @(negedge clk);
      check("sb4_drained", q4.size(), 0);
      check("sb1_drained", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
